// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered hex 7-segment scan driver.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero digit.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        div_cnt_q,  div_cnt_d;
  logic [IDX_W-1:0]        dig_idx_q,  dig_idx_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q,  disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q,  pend_dp_d;
  logic                    pending_q,  pending_d;
  logic [6:0]              seg_q,      seg_d;
  logic                    dp_q,       dp_d;
  logic [NUM_DIGITS-1:0]   an_q,       an_d;

  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              nib_sel;
  logic                    dp_sel;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              seg_dec;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h3F;
      4'h1: hex2seg = 7'h06;
      4'h2: hex2seg = 7'h5B;
      4'h3: hex2seg = 7'h4F;
      4'h4: hex2seg = 7'h66;
      4'h5: hex2seg = 7'h6D;
      4'h6: hex2seg = 7'h7D;
      4'h7: hex2seg = 7'h07;
      4'h8: hex2seg = 7'h7F;
      4'h9: hex2seg = 7'h6F;
      4'hA: hex2seg = 7'h77;
      4'hB: hex2seg = 7'h7C;
      4'hC: hex2seg = 7'h39;
      4'hD: hex2seg = 7'h5E;
      4'hE: hex2seg = 7'h79;
      4'hF: hex2seg = 7'h71;
    endcase
  endfunction

  // Scan position and buffer hand-over; a load on the boundary cycle still
  // lets the previously pending data move to the display first.
  always_comb begin
    slot_end   = en && (div_cnt_q == LAST_CNT);
    frame_end  = slot_end && (dig_idx_q == LAST_IDX);
    div_cnt_d  = div_cnt_q;
    dig_idx_d  = dig_idx_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pending_d  = pending_q;

    if (en) begin
      div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
    end
    if (slot_end) begin
      dig_idx_d = frame_end ? '0 : dig_idx_q + 1'b1;
    end
    if (frame_end && pending_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      pending_d  = 1'b0;
    end
    if (load) begin
      pend_val_d = value_in;
      pend_dp_d  = dp_in;
      pending_d  = 1'b1;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_blank;

  always_comb begin : lz_blank_comb
    logic nz_above;
    nz_above = 1'b0;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      nz_above    = nz_above | (disp_val_q[4*k +: 4] != 4'h0);
      lz_blank[k] = ~nz_above;
    end
  end
`endif

  always_comb begin
    nib_sel = '0;
    dp_sel  = 1'b0;
    an_sel  = '0;
    seg_d   = '0;
    dp_d    = 1'b0;
    an_d    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_idx_q == IDX_W'(k)) begin
        nib_sel   = disp_val_q[4*k +: 4];
        dp_sel    = disp_dp_q[k];
        an_sel[k] = 1'b1;
      end
    end
    seg_dec = hex2seg(nib_sel);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if ((lz_blank & an_sel) != '0) begin
      seg_dec = 7'h00;
    end
`endif
    if (en) begin
      seg_d = seg_dec;
      dp_d  = dp_sel;
      an_d  = an_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      dig_idx_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pending_q  <= 1'b0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      an_q       <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      dig_idx_q  <= dig_idx_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pending_q  <= pending_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg        = seg_q ^ {7{ACTIVE_LOW}};
  assign dp         = dp_q ^ ACTIVE_LOW;
  assign an         = an_q ^ {NUM_DIGITS{ACTIVE_LOW}};
  assign frame_done = frame_end;
  assign pending    = pending_q;

endmodule
